// File: rtl/data_mem_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder_if
//  Description : Per-channel LSU <-> data-memory request/response bundle.
//                The LSU array drives the master side; the memory responder
//                sits on the slave side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface data_mem_responder_if #(
    parameter int NUM_CHANNELS         = 4,
    parameter int CACHE_LINE_BYTE_SIZE = 4,
    parameter int ADDR_WIDTH           = 32
);
    localparam int c_DATA_W = CACHE_LINE_BYTE_SIZE * 8;

    logic [NUM_CHANNELS-1:0]                           mem_valid;
    logic [NUM_CHANNELS-1:0][ADDR_WIDTH-1:0]           mem_addr;
    logic [NUM_CHANNELS-1:0][c_DATA_W-1:0]             mem_data;
    logic [NUM_CHANNELS-1:0][CACHE_LINE_BYTE_SIZE-1:0] mem_we;
    logic [NUM_CHANNELS-1:0]                           mem_resp_ready;
    logic [NUM_CHANNELS-1:0][c_DATA_W-1:0]             mem_resp_data;

    modport master (
        output mem_valid, mem_addr, mem_data, mem_we,
        input  mem_resp_ready, mem_resp_data
    );

    modport slave (
        input  mem_valid, mem_addr, mem_data, mem_we,
        output mem_resp_ready, mem_resp_data
    );
endinterface
`default_nettype wire

// File: rtl/data_mem_responder.sv
`default_nettype none
// ============================================================================
//  Module      : data_mem_responder
//  Description : Round-robin data-memory responder for a warp's LSU ports.
//                Serves one request at a time against a word-organised,
//                byte-writable array and returns a one-cycle ready pulse
//                LATENCY edges after the grant edge.
//  Revision    : 1.0 - initial release
// ============================================================================
module data_mem_responder #(
    parameter int NUM_CHANNELS         = 4,
    parameter int DEPTH_WORDS          = 256,
    parameter int LATENCY              = 2,
    parameter int CACHE_LINE_BYTE_SIZE = 4,
    parameter int ADDR_WIDTH           = 32
) (
    input  wire                 clk,
    input  wire                 reset,
    data_mem_responder_if.slave bus,
    output logic                busy
);
    localparam int c_IDX_W  = $clog2(DEPTH_WORDS);
    localparam int c_CH_W   = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam int c_CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam int c_DATA_W = CACHE_LINE_BYTE_SIZE * 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_BUSY    = 2'd1,
        S_RESPOND = 2'd2
    } state_t;

    state_t                          r_state;
    logic [c_CH_W-1:0]               r_rr_ptr;
    logic [c_CH_W-1:0]               r_grant;
    logic [c_CNT_W-1:0]              r_cnt;
    logic [c_IDX_W-1:0]              r_word;
    logic [c_DATA_W-1:0]             r_wdata;
    logic [CACHE_LINE_BYTE_SIZE-1:0] r_we;
    logic [c_DATA_W-1:0]             r_rd_data;
    logic [NUM_CHANNELS-1:0]         r_ready;
    logic                            r_busy;
    logic [c_DATA_W-1:0]             r_mem [DEPTH_WORDS];

    logic                            w_found;
    logic [c_CH_W-1:0]               w_grant;
    logic                            w_access;
    logic                            w_unused_addr;

    // Only the word-index bits of the address matter; the rest wrap/ignore.
    assign w_unused_addr = ^bus.mem_addr;

    // Round-robin pick: first valid channel at or after r_rr_ptr. The scan
    // runs from the farthest offset down so the nearest one wins.
    always_comb begin
        int k;
        k       = 0;
        w_found = 1'b0;
        w_grant = '0;
        for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
            k = (int'(r_rr_ptr) + i) % NUM_CHANNELS;
            if (bus.mem_valid[k[c_CH_W-1:0]]) begin
                w_found = 1'b1;
                w_grant = c_CH_W'(k);
            end
        end
    end

    // The array is read and written on the edge that leaves BUSY.
    assign w_access = (r_state == S_BUSY) && (r_cnt == '0);

    // Control FSM: grant latch, latency countdown, read capture, ready pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_rr_ptr  <= '0;
            r_grant   <= '0;
            r_cnt     <= '0;
            r_word    <= '0;
            r_wdata   <= '0;
            r_we      <= '0;
            r_rd_data <= '0;
            r_ready   <= '0;
            r_busy    <= 1'b0;
        end else begin
            r_ready <= '0;
            case (r_state)
                S_IDLE: begin
                    if (w_found) begin
                        r_grant  <= w_grant;
                        r_word   <= bus.mem_addr[w_grant][c_IDX_W+1:2];
                        r_wdata  <= bus.mem_data[w_grant];
                        r_we     <= bus.mem_we[w_grant];
                        r_rr_ptr <= (w_grant == c_CH_W'(NUM_CHANNELS - 1)) ?
                                    '0 : w_grant + c_CH_W'(1);
                        // BUSY lasts LATENCY cycles, so the ready pulse lands
                        // in the cycle after grant edge + LATENCY.
                        r_cnt    <= c_CNT_W'(LATENCY - 1);
                        r_state  <= S_BUSY;
                        r_busy   <= 1'b1;
                    end
                end
                S_BUSY: begin
                    if (r_cnt == '0) begin
                        r_rd_data        <= r_mem[r_word];
                        r_ready[r_grant] <= 1'b1;
                        r_state          <= S_RESPOND;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_W'(1);
                    end
                end
                S_RESPOND: begin
                    // Mandatory IDLE cycle lets the served LSU drop its valid.
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    // Byte-lane write; the read capture above sees the pre-write word.
    always_ff @(posedge clk) begin
        if (w_access && !reset) begin
            for (int b = 0; b < CACHE_LINE_BYTE_SIZE; b++) begin
                if (r_we[b]) begin
                    r_mem[r_word][b*8 +: 8] <= r_wdata[b*8 +: 8];
                end
            end
        end
    end

    assign bus.mem_resp_ready = r_ready;
    assign busy               = r_busy;

    generate
        for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_resp
            assign bus.mem_resp_data[g] = r_rd_data;
        end
    endgenerate
endmodule
`default_nettype wire
